// File: rtl/uart_ascii_pkg.sv
// ASCII constants and hex-digit helpers shared by the UART result-line
// receiver and the matching TX-side sender.
package uart_ascii_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Returns {is_hex, nib}; nib is 0 when the byte is not a hex digit.
  function automatic logic [4:0] hex_nibble(input logic [7:0] b, input logic allow_lower);
    logic [7:0] d;
    logic [4:0] r;
    r = '0;
    d = '0;
    if (b >= 8'h30 && b <= 8'h39) begin
      d = b - 8'h30;
      r = {1'b1, d[3:0]};
    end else if (b >= 8'h41 && b <= 8'h46) begin
      d = b - 8'h37;
      r = {1'b1, d[3:0]};
    end else if (allow_lower && b >= 8'h61 && b <= 8'h66) begin
      d = b - 8'h57;
      r = {1'b1, d[3:0]};
    end
    return r;
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/result_line_receiver.sv
// Parses "RES:XXXXXXXX\r\n" from a UART RX byte stream and publishes the
// 32-bit value with a one-cycle strobe; malformed frames are flagged once.
module result_line_receiver
  import uart_ascii_pkg::*;
#(
  parameter logic [31:0] PREFIX      = 32'h5245_533A,
  parameter bit          ALLOW_LOWER = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        frame_err,
  output logic        in_frame
);

  typedef enum logic [2:0] {MATCH, HEX, EXP_CR, EXP_LF, DISCARD} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] shreg;
  logic [7:0]  pfx_byte;
  logic [4:0]  dec;

  always_comb begin
    pfx_byte = PREFIX[31:24];
    case (idx[1:0])
      2'd0: pfx_byte = PREFIX[31:24];
      2'd1: pfx_byte = PREFIX[23:16];
      2'd2: pfx_byte = PREFIX[15:8];
      2'd3: pfx_byte = PREFIX[7:0];
      default: pfx_byte = PREFIX[31:24];
    endcase
  end

  assign dec      = hex_nibble(rx_data, ALLOW_LOWER);
  assign in_frame = (state == HEX) || (state == EXP_CR) ||
                    (state == EXP_LF) || (state == DISCARD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MATCH;
      idx         <= '0;
      shreg       <= '0;
      value       <= '0;
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        MATCH: if (rx_valid) begin
          if (rx_data == pfx_byte) begin
            if (idx == 3'd3) begin
              idx   <= '0;
              state <= HEX;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            // A stray tag-start byte may begin a real frame: restart on it.
            idx <= (rx_data == PREFIX[31:24]) ? 3'd1 : 3'd0;
          end
        end
        HEX: if (rx_valid) begin
          if (dec[4]) begin
            shreg <= {shreg[27:0], dec[3:0]};
            if (idx == 3'd7) begin
              idx   <= '0;
              state <= EXP_CR;
            end else begin
              idx <= idx + 3'd1;
            end
          end else begin
            idx       <= '0;
            frame_err <= 1'b1;
            state     <= DISCARD;
          end
        end
        EXP_CR: if (rx_valid) begin
          if (rx_data == ASCII_CR) begin
            state <= EXP_LF;
          end else if (rx_data == ASCII_LF) begin
            value       <= shreg;
            value_valid <= 1'b1;
            state       <= MATCH;
          end else begin
            frame_err <= 1'b1;
            state     <= DISCARD;
          end
        end
        EXP_LF: if (rx_valid) begin
          if (rx_data == ASCII_LF) begin
            value       <= shreg;
            value_valid <= 1'b1;
            state       <= MATCH;
          end else begin
            frame_err <= 1'b1;
            state     <= DISCARD;
          end
        end
        DISCARD: if (rx_valid && rx_data == ASCII_LF) begin
          idx   <= '0;
          state <= MATCH;
        end
        default: begin
          idx   <= '0;
          state <= MATCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_result_line_receiver.sv
// Bench for result_line_receiver: table of byte strings driven into two
// instances (lowercase allowed / not), with a cycle-stamped event scoreboard.
module tb_result_line_receiver;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [31:0] value0, value1;
  logic        vv0, vv1, fe0, fe1, inf0, inf1;

  always #5 clk = ~clk;

  result_line_receiver #(.PREFIX(32'h5245_533A), .ALLOW_LOWER(1'b1)) u0 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .value(value0), .value_valid(vv0), .frame_err(fe0), .in_frame(inf0));

  result_line_receiver #(.PREFIX(32'h5245_533A), .ALLOW_LOWER(1'b0)) u1 (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .value(value1), .value_valid(vv1), .frame_err(fe1), .in_frame(inf1));

  typedef struct {
    string       s;
    int          gap;    // idle cycles after every byte
    bit          chain;  // next row follows with no drain/check
    bit          vv0;
    bit          vv1;
    logic [31:0] val;
    int          err0;   // byte index expected to raise frame_err, -1 none
    int          err1;
  } row_t;

  typedef struct {
    bit          is_err;
    logic [31:0] val;
    int          cyc;
  } ev_t;

  ev_t         q[2][$];
  row_t        rows[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] lg0, lg1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic vv, input logic fe, input logic [31:0] v);
    ev_t ev;
    if (vv || fe) begin
      checks++;
      if (q[id].size() == 0) begin
        errors++;
        $display("FAIL pulse%0d: got vv=%0b fe=%0b at cycle %0d, expected no pulse", id, vv, fe, cyc);
      end else begin
        ev = q[id].pop_front();
        if (ev.is_err != fe || ev.is_err == vv || ev.cyc != cyc || (vv && v !== ev.val)) begin
          errors++;
          $display("FAIL pulse%0d: got vv=%0b fe=%0b val=%h cyc=%0d, expected err=%0b val=%h cyc=%0d",
                   id, vv, fe, v, cyc, ev.is_err, ev.val, ev.cyc);
        end
      end
    end
  endtask

  always @(negedge clk) if (!rst) begin
    mon(0, vv0, fe0, value0);
    mon(1, vv1, fe1, value1);
  end

  function automatic row_t mk(string s, int gap, bit chain, bit v0, bit v1,
                              logic [31:0] val, int e0, int e1);
    row_t r;
    r.s = s; r.gap = gap; r.chain = chain; r.vv0 = v0; r.vv1 = v1;
    r.val = val; r.err0 = e0; r.err1 = e1;
    return r;
  endfunction

  task automatic push(input int id, input bit is_err, input logic [31:0] val);
    ev_t ev;
    ev.is_err = is_err; ev.val = val; ev.cyc = cyc + 1;
    q[id].push_back(ev);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic drain_and_check(input string name);
    repeat (2) begin @(posedge clk); #1; end
    chk({name, " q0 empty"}, q[0].size(), 0);
    chk({name, " q1 empty"}, q[1].size(), 0);
    chk({name, " value0"}, value0, lg0);
    chk({name, " value1"}, value1, lg1);
    chk({name, " in_frame0"}, {31'd0, inf0}, 32'd0);
  endtask

  task automatic send_row(input row_t r, input int n);
    int last;
    last = r.s.len() - 1;
    for (int i = 0; i <= last; i++) begin
      if (i == r.err0) push(0, 1'b1, '0);
      if (i == r.err1) push(1, 1'b1, '0);
      if (i == last && r.vv0) push(0, 1'b0, r.val);
      if (i == last && r.vv1) push(1, 1'b0, r.val);
      send_byte(r.s[i], r.gap);
    end
    if (r.vv0) lg0 = r.val;
    if (r.vv1) lg1 = r.val;
    if (!r.chain) drain_and_check($sformatf("row%0d", n));
  endtask

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    lg0 = '0; lg1 = '0;
    rows.push_back(mk("RES:DEADBEEF\015\012",       0, 1, 1, 1, 32'hDEADBEEF, -1, -1));
    rows.push_back(mk("RES:0000abcd\012",            0, 0, 1, 0, 32'h0000ABCD, -1,  8));
    rows.push_back(mk("xxRERES:12345678\015\012",   0, 0, 1, 1, 32'h12345678, -1, -1));
    rows.push_back(mk("RES:12G45678\015\012",       0, 1, 0, 0, 32'h0,         6,  6));
    rows.push_back(mk("RES:CAFEF00D\015\012",       0, 0, 1, 1, 32'hCAFEF00D, -1, -1));
    rows.push_back(mk("RES:0F1E2D3C\015\012",       2, 1, 1, 1, 32'h0F1E2D3C, -1, -1));
    rows.push_back(mk("RES:A5A5A5A5\012",            2, 0, 1, 1, 32'hA5A5A5A5, -1, -1));
    rows.push_back(mk("RES:11111111\015X\012",      0, 1, 0, 0, 32'h0,        13, 13));
    rows.push_back(mk("RES:FFFFFFFF\015\012",       0, 0, 1, 1, 32'hFFFFFFFF, -1, -1));
    rows.push_back(mk("RES:12345678Z\012",          0, 0, 0, 0, 32'h0,        12, 12));
    rows.push_back(mk("RES:1Z2Y\012",                0, 0, 0, 0, 32'h0,         5,  5));
    rows.push_back(mk("RES:00C0FFEE\012",            0, 0, 1, 1, 32'h00C0FFEE, -1, -1));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset value0", value0, 32'h0);
    chk("reset vv/fe/in_frame", {29'd0, vv0, fe0, inf0}, 32'd0);
    rst = 1'b0;

    foreach (rows[n]) send_row(rows[n], n);

    // Reset mid-frame: partial frame dropped, reset wins over a same-cycle byte
    for (int i = 0; i < 6; i++) send_byte(8'(i == 0 ? "R" : i == 1 ? "E" : i == 2 ? "S" :
                                             i == 3 ? ":" : i == 4 ? "1" : "2"), 0);
    chk("mid-frame in_frame", {31'd0, inf0}, 32'd1);
    rst = 1'b1; rx_data = "3"; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0; rst = 1'b0;
    chk("rst value0", value0, 32'h0);
    chk("rst value1", value1, 32'h0);
    chk("rst flags", {26'd0, vv0, fe0, inf0, vv1, fe1, inf1}, 32'd0);
    lg0 = '0; lg1 = '0;
    send_row(mk("RES:87654321\015\012", 0, 0, 1, 1, 32'h87654321, -1, -1), 99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
